// File: rtl/addsub_byte_seq_if.sv
// addsub_byte_seq_if: request, result and 8-bit unit bundle
// for the multi-byte add/sub sequencer.
interface addsub_byte_seq_if #(
   parameter int NBYTES = 2
);
   localparam int W = 8 * NBYTES;

   logic         in_valid;
   logic         in_ready;
   logic         in_op;
   logic         in_ci;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;

   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_r;
   logic         out_co;
   logic         out_ovf;

   logic         au_op;
   logic         au_ci;
   logic [7:0]   au_x;
   logic [7:0]   au_y;
   logic [7:0]   au_r;
   logic         au_co;

   modport slave (
      input  in_valid, in_op, in_ci, in_a, in_b,
      input  out_ready, au_r, au_co,
      output in_ready, out_valid, out_r, out_co, out_ovf,
      output au_op, au_ci, au_x, au_y
   );

   modport master (
      output in_valid, in_op, in_ci, in_a, in_b,
      output out_ready, au_r, au_co,
      input  in_ready, out_valid, out_r, out_co, out_ovf,
      input  au_op, au_ci, au_x, au_y
   );
endinterface

// File: rtl/addsub_byte_seq.sv
// addsub_byte_seq: feeds an external 8-bit add/sub unit one byte
// per cycle LSB first, chaining carry, and returns the wide result.
module addsub_byte_seq #(
   parameter int NBYTES = 2
) (
   input logic              clk,
   input logic              rst,
   addsub_byte_seq_if.slave bus
);
   localparam int W  = 8 * NBYTES;
   localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t        r_state;
   logic [W-1:0]  r_a;
   logic [W-1:0]  r_b;
   logic [W-1:0]  r_r;
   logic [KW-1:0] r_k;
   logic          r_op;
   logic          r_sa;
   logic          r_sb;
   logic          r_co;
   logic          r_ovf;
   logic          r_valid;
   logic [7:0]    r_au_x;
   logic [7:0]    r_au_y;
   logic          r_au_op;
   logic          r_au_ci;

   logic [W-1:0]  w_a_nxt;
   logic [W-1:0]  w_b_nxt;
   logic [W-1:0]  w_r_nxt;
   logic          w_ovf;

   // Operands shift down a byte per step so the unit always sees byte 0;
   // result bytes enter at the top and end up in place after NBYTES steps.
   assign w_a_nxt = r_a >> 8;
   assign w_b_nxt = r_b >> 8;
   assign w_r_nxt = W'({bus.au_r, r_r} >> 8);
   assign w_ovf   = (r_sa == (r_sb ^ r_op)) && (bus.au_r[7] != r_sa);

   // Outputs come straight from state registers; in_ready is also
   // held low while reset is asserted.
   assign bus.in_ready  = (r_state == S_IDLE) && !rst;
   assign bus.out_valid = r_valid;
   assign bus.out_r     = r_r;
   assign bus.out_co    = r_co;
   assign bus.out_ovf   = r_ovf;
   assign bus.au_x      = r_au_x;
   assign bus.au_y      = r_au_y;
   assign bus.au_op     = r_au_op;
   assign bus.au_ci     = r_au_ci;

   // Sequencer FSM: accept, run one byte per cycle, hold result.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_r     <= '0;
         r_k     <= '0;
         r_op    <= 1'b0;
         r_sa    <= 1'b0;
         r_sb    <= 1'b0;
         r_co    <= 1'b0;
         r_ovf   <= 1'b0;
         r_valid <= 1'b0;
         r_au_x  <= '0;
         r_au_y  <= '0;
         r_au_op <= 1'b0;
         r_au_ci <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (bus.in_valid) begin
                  r_a     <= bus.in_a;
                  r_b     <= bus.in_b;
                  r_op    <= bus.in_op;
                  r_sa    <= bus.in_a[W-1];
                  r_sb    <= bus.in_b[W-1];
                  r_k     <= '0;
                  r_au_x  <= bus.in_a[7:0];
                  r_au_y  <= bus.in_b[7:0];
                  r_au_op <= bus.in_op;
                  r_au_ci <= bus.in_ci;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_r <= w_r_nxt;
               if (r_k == K_LAST) begin
                  r_co    <= bus.au_co;
                  r_ovf   <= w_ovf;
                  r_valid <= 1'b1;
                  r_au_x  <= '0;
                  r_au_y  <= '0;
                  r_au_op <= 1'b0;
                  r_au_ci <= 1'b0;
                  r_state <= S_DONE;
               end else begin
                  r_k     <= r_k + 1'b1;
                  r_a     <= w_a_nxt;
                  r_b     <= w_b_nxt;
                  r_au_x  <= w_a_nxt[7:0];
                  r_au_y  <= w_b_nxt[7:0];
                  r_au_ci <= bus.au_co;
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  r_valid <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_addsub_byte_seq.sv
// tb_addsub_byte_seq: directed scoreboard bench for the 2-byte build
// plus a 1-byte build, each with a behavioural 8-bit add/sub unit.
module tb_addsub_byte_seq;
   typedef struct packed {
      logic [15:0] r;
      logic        co;
      logic        ovf;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_err = 0;
   exp_t q2[$];

   addsub_byte_seq_if #(.NBYTES(2)) b2 ();
   addsub_byte_seq_if #(.NBYTES(1)) b1 ();

   addsub_byte_seq #(.NBYTES(2)) u2 (
      .clk (clk),
      .rst (rst),
      .bus (b2.slave)
   );

   addsub_byte_seq #(.NBYTES(1)) u1 (
      .clk (clk),
      .rst (rst),
      .bus (b1.slave)
   );

   always #5 clk = ~clk;

   assign {b2.au_co, b2.au_r} = {1'b0, b2.au_x}
      + {1'b0, (b2.au_op ? ~b2.au_y : b2.au_y)} + {8'd0, b2.au_ci};
   assign {b1.au_co, b1.au_r} = {1'b0, b1.au_x}
      + {1'b0, (b1.au_op ? ~b1.au_y : b1.au_y)} + {8'd0, b1.au_ci};

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model2(logic [15:0] a, logic [15:0] b,
                                   logic op, logic ci);
      exp_t        e;
      logic [15:0] y;
      logic [16:0] s;
      int          t;
      y     = op ? ~b : b;
      s     = {1'b0, a} + {1'b0, y} + {16'd0, ci};
      t     = int'($signed(a)) + int'($signed(y)) + (ci ? 1 : 0);
      e.r   = s[15:0];
      e.co  = s[16];
      e.ovf = (t > 32767) || (t < -32768);
      return e;
   endfunction

   task automatic send2(logic [15:0] a, logic [15:0] b,
                        logic op, logic ci, bit push);
      int n = 0;
      while (!b2.in_ready && n < 50) begin
         step();
         n++;
      end
      chk("in_ready_wait", b2.in_ready, 1);
      b2.in_a     = a;
      b2.in_b     = b;
      b2.in_op    = op;
      b2.in_ci    = ci;
      b2.in_valid = 1'b1;
      step();
      b2.in_valid = 1'b0;
      b2.in_a     = 16'hDEAD;
      b2.in_b     = 16'hBEEF;
      b2.in_op    = ~op;
      b2.in_ci    = ~ci;
      if (push) q2.push_back(model2(a, b, op, ci));
   endtask

   task automatic recv2(string tag, int lat0);
      int   lat = lat0;
      exp_t e;
      while (!b2.out_valid && lat < 30) begin
         step();
         lat++;
      end
      chk({tag, "_latency"}, lat, 2);
      chk({tag, "_sb_nonempty"}, (q2.size() > 0), 1);
      if (q2.size() > 0) begin
         e = q2.pop_front();
         chk({tag, "_r"}, b2.out_r, e.r);
         chk({tag, "_co"}, b2.out_co, e.co);
         chk({tag, "_ovf"}, b2.out_ovf, e.ovf);
      end
      if (b2.out_ready) begin
         step();
         chk({tag, "_valid_drop"}, b2.out_valid, 0);
      end
   endtask

   initial begin
      exp_t e4;
      int   lat;
      rst          = 1'b1;
      b2.in_valid  = 1'b0;
      b2.in_op     = 1'b0;
      b2.in_ci     = 1'b0;
      b2.in_a      = '0;
      b2.in_b      = '0;
      b2.out_ready = 1'b1;
      b1.in_valid  = 1'b0;
      b1.in_op     = 1'b0;
      b1.in_ci     = 1'b0;
      b1.in_a      = '0;
      b1.in_b      = '0;
      b1.out_ready = 1'b1;
      step();
      step();

      // reset state
      chk("rst_out_valid", b2.out_valid, 0);
      chk("rst_in_ready", b2.in_ready, 0);
      chk("rst_out_r", b2.out_r, 0);
      chk("rst_out_co", b2.out_co, 0);
      chk("rst_out_ovf", b2.out_ovf, 0);
      chk("rst_au_x", b2.au_x, 0);
      chk("rst_au_op", b2.au_op, 0);
      rst = 1'b0;
      step();
      chk("idle_in_ready", b2.in_ready, 1);

      // carry chaining across bytes
      send2(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1);
      chk("t1_c1_au_x", b2.au_x, 8'hFF);
      chk("t1_c1_au_y", b2.au_y, 8'h01);
      chk("t1_c1_au_ci", b2.au_ci, 0);
      chk("t1_c1_in_ready", b2.in_ready, 0);
      step();
      chk("t1_c2_au_x", b2.au_x, 8'h00);
      chk("t1_c2_au_ci", b2.au_ci, 1);
      chk("t1_c2_valid", b2.out_valid, 0);
      recv2("t1", 1);
      chk("t1_r_const", b2.out_r, 16'h0100);
      chk("t1_idle_au_x", b2.au_x, 0);

      // subtraction
      send2(16'h0000, 16'h0001, 1'b1, 1'b1, 1'b1);
      recv2("t2a", 0);
      chk("t2a_r_const", b2.out_r, 16'hFFFF);
      send2(16'h0005, 16'h0003, 1'b1, 1'b1, 1'b1);
      recv2("t2b", 0);
      chk("t2b_co_const", b2.out_co, 1);

      // signed overflow
      send2(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
      recv2("t3a", 0);
      chk("t3a_ovf_const", b2.out_ovf, 1);
      send2(16'h8000, 16'h0001, 1'b1, 1'b1, 1'b1);
      recv2("t3b", 0);
      chk("t3b_r_const", b2.out_r, 16'h7FFF);

      // backpressure
      b2.out_ready = 1'b0;
      e4 = model2(16'h1234, 16'h0F0F, 1'b0, 1'b1);
      send2(16'h1234, 16'h0F0F, 1'b0, 1'b1, 1'b1);
      recv2("t4", 0);
      b2.in_valid = 1'b1;
      b2.in_a     = 16'h5555;
      b2.in_b     = 16'h5555;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t4_hold_valid", b2.out_valid, 1);
         chk("t4_hold_r", b2.out_r, e4.r);
         chk("t4_hold_co", b2.out_co, e4.co);
         chk("t4_hold_in_ready", b2.in_ready, 0);
      end
      b2.in_valid  = 1'b0;
      b2.out_ready = 1'b1;
      step();
      chk("t4_release_valid", b2.out_valid, 0);
      chk("t4_release_in_ready", b2.in_ready, 1);
      step();
      chk("t4_no_accept_au_x", b2.au_x, 0);
      chk("t4_no_accept_valid", b2.out_valid, 0);

      // reset mid-run
      send2(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
      step();
      rst = 1'b1;
      step();
      chk("t5_rst_valid", b2.out_valid, 0);
      chk("t5_rst_au_x", b2.au_x, 0);
      chk("t5_rst_au_y", b2.au_y, 0);
      chk("t5_rst_au_ci", b2.au_ci, 0);
      chk("t5_rst_in_ready", b2.in_ready, 0);
      rst = 1'b0;
      step();
      chk("t5_post_in_ready", b2.in_ready, 1);
      chk("t5_post_valid", b2.out_valid, 0);
      send2(16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1);
      recv2("t5", 0);
      chk("t5_r_const", b2.out_r, 16'h2345);

      // assorted operands
      for (int i = 0; i < 6; i++) begin
         logic [15:0] ra;
         logic [15:0] rb;
         logic        rop;
         ra  = 16'($urandom);
         rb  = 16'($urandom);
         rop = 1'($urandom);
         send2(ra, rb, rop, rop, 1'b1);
         recv2("rnd", 0);
      end

      // single-byte build
      b1.in_a     = 8'h80;
      b1.in_b     = 8'h80;
      b1.in_op    = 1'b0;
      b1.in_ci    = 1'b0;
      b1.in_valid = 1'b1;
      chk("t6_in_ready", b1.in_ready, 1);
      step();
      b1.in_valid = 1'b0;
      b1.in_a     = 8'h11;
      lat = 0;
      while (!b1.out_valid && lat < 30) begin
         step();
         lat++;
      end
      chk("t6_latency", lat, 1);
      chk("t6_r", b1.out_r, 8'h00);
      chk("t6_co", b1.out_co, 1);
      chk("t6_ovf", b1.out_ovf, 1);
      step();
      chk("t6_valid_drop", b1.out_valid, 0);

      chk("sb_drained", q2.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_err);
      $finish;
   end
endmodule
